isqrt_pipe: RTL and testbench

Pipelined integer square root unit: y = floor(sqrt(x)) for a 32-bit unsigned x, with a 16-bit result.
It is the isqrt engine attached to the isqrt_x / isqrt_y interface of the formula FSMs: it consumes isqrt_x_vld / isqrt_x and produces isqrt_y_vld / isqrt_y.
It accepts one operand per clock with no backpressure and returns results in issue order after a fixed latency.

---
 rtl/isqrt_pipe.sv | 121 ++++++++++++
 tb/tb_isqrt_pipe.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/isqrt_pipe.sv
// Pipelined floor(sqrt(x)) for 32-bit unsigned operands, 16-bit root.
// Restoring remainder form, 16/N_STAGES root bits resolved per register stage.

module isqrt_stage #(
   parameter int ITERS = 1
) (
   input  logic [15:0] rem_i,
   input  logic [15:0] root_i,
   input  logic [31:0] x_i,
   output logic [15:0] rem_o,
   output logic [15:0] root_o,
   output logic [31:0] x_o
);

   logic [15:0] r;
   logic [15:0] q;
   logic [31:0] xs;
   logic [17:0] sh;
   logic [17:0] trial;

   // x is left-aligned: each iteration consumes its top two bits and shifts.
   // Between iterations rem <= 2*root < 2^16, so 16 bits carry it; only the
   // very last iteration can exceed that, and its remainder is never used.
   always_comb begin
      r     = rem_i;
      q     = root_i;
      xs    = x_i;
      sh    = '0;
      trial = '0;
      for (int j = 0; j < ITERS; j++) begin
         sh    = {r, xs[31:30]};
         trial = {q, 2'b01};
         xs    = {xs[29:0], 2'b00};
         if (sh >= trial) begin
            r = 16'(sh - trial);
            q = {q[14:0], 1'b1};
         end else begin
            r = sh[15:0];
            q = {q[14:0], 1'b0};
         end
      end
      rem_o  = r;
      root_o = q;
      x_o    = xs;
   end

endmodule

module isqrt_pipe #(
   parameter int N_STAGES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        x_vld,
   input  logic [31:0] x,
   output logic        y_vld,
   output logic [15:0] y
);

   localparam int ITERS = (N_STAGES > 0) ? 16 / N_STAGES : 1;

   if (!(N_STAGES == 1 || N_STAGES == 2 || N_STAGES == 4 ||
         N_STAGES == 8 || N_STAGES == 16)) begin : g_bad_param
      $error("isqrt_pipe: N_STAGES must be 1, 2, 4, 8 or 16");
   end

   logic [N_STAGES:0]            vld_pipe;
   logic [N_STAGES-1:0][15:0]    out_rem;
   logic [N_STAGES-1:0][15:0]    out_root;
   logic [N_STAGES-1:0][31:0]    out_x;
   logic [15:0]                  y_q;
   logic                         unused_tail;

   assign vld_pipe[0] = x_vld;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) vld_pipe[N_STAGES:1] <= '0;
      else      vld_pipe[N_STAGES:1] <= vld_pipe[N_STAGES-1:0];
   end

   for (genvar s = 0; s < N_STAGES; s++) begin : g_stage
      logic [15:0] rem_in;
      logic [15:0] root_in;
      logic [31:0] x_in;

      if (s == 0) begin : g_head
         assign rem_in  = '0;
         assign root_in = '0;
         assign x_in    = x;
      end else begin : g_reg
         // Data is not reset; bubbles just keep stale values.
         always_ff @(posedge clk) begin
            if (vld_pipe[s-1]) begin
               rem_in  <= out_rem[s-1];
               root_in <= out_root[s-1];
               x_in    <= out_x[s-1];
            end
         end
      end

      isqrt_stage #(.ITERS(ITERS)) u_stage (
         .rem_i  (rem_in),
         .root_i (root_in),
         .x_i    (x_in),
         .rem_o  (out_rem[s]),
         .root_o (out_root[s]),
         .x_o    (out_x[s])
      );
   end

   always_ff @(posedge clk) begin
      if (vld_pipe[N_STAGES-1]) y_q <= out_root[N_STAGES-1];
   end

   // Final remainder and fully consumed operand have no consumer.
   assign unused_tail = ^{out_rem[N_STAGES-1], out_x[N_STAGES-1]};

   assign y_vld = vld_pipe[N_STAGES];
   assign y     = y_q;

endmodule

// File: tb/tb_isqrt_pipe.sv
// Scoreboard bench: one stimulus stream drives isqrt_pipe at N_STAGES = 1, 4, 8, 16;
// a monitor per instance checks value, latency and absence of stray pulses.

module tb_isqrt_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        x_vld = 1'b0;
   logic [31:0] x = '0;
   logic        y_vld_w [4];
   logic [15:0] y_w [4];

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   logic [15:0] exp_val [$];
   int          exp_cyc [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input int k, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, k, cyc, got, exp);
      end
   endtask

   // Independent model: the direct candidate-squaring form with 64-bit products.
   function automatic logic [15:0] ref_isqrt(input logic [31:0] v);
      logic [15:0] r;
      logic [15:0] c;
      r = '0;
      for (int i = 15; i >= 0; i--) begin
         c = r | (16'd1 << i);
         if (64'(c) * 64'(c) <= 64'(v)) r = c;
      end
      return r;
   endfunction

   for (genvar k = 0; k < 4; k++) begin : g_dut
      localparam int L = (k == 0) ? 1 : (k == 1) ? 4 : (k == 2) ? 8 : 16;
      int rd;

      isqrt_pipe #(.N_STAGES(L)) u_dut (
         .clk   (clk),
         .rst   (rst),
         .x_vld (x_vld),
         .x     (x),
         .y_vld (y_vld_w[k]),
         .y     (y_w[k])
      );

      initial begin
         rd = 0;
         forever begin
            @(negedge clk);
            if (!rst) begin
               check("y_vld_in_reset", k, 32'(y_vld_w[k]), 32'd0);
               rd = exp_val.size();
            end else if (rd < exp_val.size() && exp_cyc[rd] + L == cyc) begin
               check("y_vld_latency", k, 32'(y_vld_w[k]), 32'd1);
               if (y_vld_w[k] === 1'b1) check("y_value", k, 32'(y_w[k]), 32'(exp_val[rd]));
               rd++;
            end else begin
               check("y_vld_spurious", k, 32'(y_vld_w[k]), 32'd0);
            end
         end
      end
   end

   task automatic step(input logic v, input logic [31:0] xv, input logic [15:0] e);
      @(posedge clk);
      #1;
      x_vld = v;
      x     = xv;
      if (v) begin
         exp_val.push_back(e);
         exp_cyc.push_back(cyc);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 16'd0);
   endtask

   initial begin
      logic [31:0] rx;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 4; k++) check("reset_y_vld", k, 32'(y_vld_w[k]), 32'd0);
      rst = 1'b1;

      // single issues, each isolated so the pulse width is visible
      step(1'b1, 32'd0,          16'd0);      idle(20);
      step(1'b1, 32'd1,          16'd1);      idle(20);
      step(1'b1, 32'd143,        16'd11);     idle(20);
      step(1'b1, 32'd144,        16'd12);     idle(20);
      step(1'b1, 32'hFFFF_FFFF,  16'hFFFF);   idle(20);

      // back-to-back stream
      step(1'b1, 32'd4,          16'd2);
      step(1'b1, 32'd15,         16'd3);
      step(1'b1, 32'd16,         16'd4);
      step(1'b1, 32'hFFFE_0000,  16'hFFFE);
      step(1'b1, 32'hFFFE_0001,  16'hFFFF);
      idle(20);

      // gapped pattern 1,0,1,1,0,0,1
      step(1'b1, 32'd1000000,    16'd1000);
      step(1'b0, 32'd99,         16'd0);
      step(1'b1, 32'd65535,      16'd255);
      step(1'b1, 32'd65536,      16'd256);
      step(1'b0, 32'd7,          16'd0);
      step(1'b0, 32'd8,          16'd0);
      step(1'b1, 32'h4000_0000,  16'h8000);
      idle(20);

      // reset mid-flight: assert while the N_STAGES=8 instance is driving y_vld
      step(1'b1, 32'd2,          16'd1);
      step(1'b1, 32'd3,          16'd1);
      step(1'b1, 32'd9,          16'd3);
      idle(6);
      rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) check("async_reset_y_vld", k, 32'(y_vld_w[k]), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      step(1'b1, 32'd50,         16'd7);
      idle(20);

      // soak with 50 % issue density
      for (int i = 0; i < 3000; i++) begin
         case ($urandom_range(3))
            0:       rx = $urandom;
            1:       rx = $urandom_range(65535);
            2:       begin rx = $urandom_range(65535); rx = rx * rx; end
            default: begin rx = $urandom_range(65535); rx = rx * rx - 32'd1; end
         endcase
         if ($urandom_range(1) == 1) step(1'b1, rx, ref_isqrt(rx));
         else                        step(1'b0, rx, 16'd0);
      end
      idle(20);

      check("drain", 0, 32'(g_dut[0].rd), 32'(exp_val.size()));
      check("drain", 1, 32'(g_dut[1].rd), 32'(exp_val.size()));
      check("drain", 2, 32'(g_dut[2].rd), 32'(exp_val.size()));
      check("drain", 3, 32'(g_dut[3].rd), 32'(exp_val.size()));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
